// File: rtl/mimc_msg_packer.sv
// rtl/mimc_msg_packer.sv - packs a byte stream into sub-modulus field elements for the MiMC core (option: MIMC_PACK_LEN_PAD_EN)
module mimc_msg_packer #(
  parameter int N_BITS         = 254,
  parameter int BYTES_PER_ELEM = 31,
  parameter int LEN_BITS       = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              core_rst,
  output logic              core_en,
  output logic [N_BITS-1:0] core_in,
  input  logic [N_BITS-1:0] core_out,
  input  logic              core_done,
  output logic [N_BITS-1:0] digest,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic              busy
);

  localparam int BUF_W = 8 * BYTES_PER_ELEM;
  localparam int IDX_W = $clog2(BYTES_PER_ELEM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_ELEM - 1);

  // An element wider than the field could exceed the modulus; the length element must also fit.
  if (BUF_W >= N_BITS || LEN_BITS >= N_BITS || LEN_BITS < 1) begin : g_bad_params
    $error("mimc_msg_packer: element or length width does not fit below N_BITS");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FILL,
    ISSUE,
    WAIT,
    LEN_ISSUE,
    LEN_WAIT,
    OUT
  } state_t;

  state_t           state;
  logic [BUF_W-1:0] pack_buf;
  logic [BUF_W-1:0] buf_next;
  logic [IDX_W-1:0] idx;
  logic             last_seen;
`ifdef MIMC_PACK_LEN_PAD_EN
  logic [LEN_BITS-1:0] len_cnt;
`endif

  // Buffer with the incoming byte merged into its little-endian slot.
  always_comb begin
    buf_next = pack_buf;
    for (int i = 0; i < BYTES_PER_ELEM; i++) begin
      if (idx == IDX_W'(i)) begin
        buf_next[8*i +: 8] = s_data;
      end
    end
  end

  // Message FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pack_buf     <= '0;
      idx          <= '0;
      last_seen    <= 1'b0;
      s_ready      <= 1'b0;
      core_rst     <= 1'b0;
      core_en      <= 1'b0;
      core_in      <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef MIMC_PACK_LEN_PAD_EN
      len_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // The byte that woke us is not consumed here; it is taken in FILL.
          if (s_valid) begin
            state    <= CLEAR;
            core_rst <= 1'b1;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          core_rst  <= 1'b0;
          pack_buf  <= '0;
          idx       <= '0;
          last_seen <= 1'b0;
`ifdef MIMC_PACK_LEN_PAD_EN
          len_cnt   <= '0;
`endif
          s_ready   <= 1'b1;
          state     <= FILL;
        end
        FILL: begin
          if (s_valid && s_ready) begin
            pack_buf <= buf_next;
            idx      <= idx + 1'b1;
`ifdef MIMC_PACK_LEN_PAD_EN
            len_cnt  <= len_cnt + 1'b1;
`endif
            if (s_last) begin
              last_seen <= 1'b1;
            end
            if (idx == LAST_IDX || s_last) begin
              s_ready <= 1'b0;
              core_en <= 1'b1;
              core_in <= N_BITS'(buf_next);
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          core_en <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            if (!last_seen) begin
              pack_buf <= '0;
              idx      <= '0;
              s_ready  <= 1'b1;
              state    <= FILL;
            end else begin
`ifdef MIMC_PACK_LEN_PAD_EN
              core_en <= 1'b1;
              core_in <= N_BITS'(len_cnt);
              state   <= LEN_ISSUE;
`else
              digest       <= core_out;
              digest_valid <= 1'b1;
              state        <= OUT;
`endif
            end
          end
        end
`ifdef MIMC_PACK_LEN_PAD_EN
        LEN_ISSUE: begin
          core_en <= 1'b0;
          state   <= LEN_WAIT;
        end
        LEN_WAIT: begin
          if (core_done) begin
            digest       <= core_out;
            digest_valid <= 1'b1;
            state        <= OUT;
          end
        end
`endif
        OUT: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mimc_msg_packer.sv
// tb/tb_mimc_msg_packer.sv - self-checking bench for mimc_msg_packer with a stand-in hash core
module tb_mimc_msg_packer;

  localparam int N   = 254;
  localparam int BPE = 31;
  localparam int LB  = 64;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         core_rst;
  logic         core_en;
  logic [N-1:0] core_in;
  logic [N-1:0] core_out;
  logic         core_done;
  logic [N-1:0] digest;
  logic         digest_valid;
  logic         digest_ready;
  logic         busy;

  mimc_msg_packer #(.N_BITS(N), .BYTES_PER_ELEM(BPE), .LEN_BITS(LB)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .core_rst(core_rst), .core_en(core_en), .core_in(core_in),
    .core_out(core_out), .core_done(core_done),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Stand-in core compression step.
  function automatic logic [N-1:0] mix(input logic [N-1:0] acc, input logic [N-1:0] x);
    logic [N-1:0] r;
    r = acc * N'(5) + x + N'(7);
    return r;
  endfunction

  // Stand-in core: result LAT cycles after en, done is a level cleared by en or core_rst.
  logic [N-1:0] core_acc;
  logic [N-1:0] core_latched;
  int           core_cnt;
  always @(posedge clk) begin
    if (rst || core_rst) begin
      core_done <= 1'b0; core_out <= '0; core_acc <= '0; core_cnt <= 0;
    end else if (core_en) begin
      core_done <= 1'b0; core_latched <= core_in; core_cnt <= LAT;
    end else if (core_cnt == 1) begin
      core_done <= 1'b1;
      core_out  <= mix(core_acc, core_latched);
      core_acc  <= mix(core_acc, core_latched);
      core_cnt  <= 0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  // Reference model: elements are consecutive 31-byte little-endian chunks, plus the length when padded.
  logic [7:0]   msg[$];
  logic [N-1:0] exp_elems[$];
  logic [N-1:0] exp_digest;

  task automatic build_expect();
    logic [N-1:0] acc;
    logic [N-1:0] e;
    acc = '0;
    exp_elems.delete();
    for (int base = 0; base < msg.size(); base += BPE) begin
      e = '0;
      for (int j = 0; j < BPE && base + j < msg.size(); j++)
        e = e | (N'(msg[base + j]) << (8 * j));
      exp_elems.push_back(e);
      acc = mix(acc, e);
    end
`ifdef MIMC_PACK_LEN_PAD_EN
    e = N'(msg.size());
    exp_elems.push_back(e);
    acc = mix(acc, e);
`endif
    exp_digest = acc;
  endtask

  // Cycle compare: each core_en must carry the next modelled element; no input taken while the core works.
  bit in_flight = 1'b0;
  bit prev_en   = 1'b0;
  bit prev_crst = 1'b0;
  int en_count  = 0;
  int rst_pulses = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (core_rst) begin
        rst_pulses++;
        chk("core_rst_single_cycle", N'(prev_crst), '0);
      end
      if (in_flight) chk("s_ready_low_while_core_busy", N'(s_ready), '0);
      if (core_en) begin
        en_count++;
        chk("core_en_single_cycle", N'(prev_en), '0);
        if (exp_elems.size() == 0) chk("core_en_unexpected", N'(1), '0);
        else chk("core_in_element", core_in, exp_elems.pop_front());
        in_flight = 1'b1;
      end else if (in_flight && core_done) begin
        in_flight = 1'b0;
      end
    end
    prev_en   = core_en;
    prev_crst = core_rst;
  end

  // Call with inputs settled just after a rising edge.
  task automatic drive_bytes(input int n, input bit gaps);
    int i   = 0;
    int cyc = 0;
    bit took;
    while (i < n && cyc < 4000) begin
      s_valid = gaps ? ((cyc % 3) != 1 && (cyc % 7) != 4) : 1'b1;
      s_data  = msg[i];
      s_last  = (i == msg.size() - 1);
      @(negedge clk);
      took = s_valid && s_ready;
      if (took && i == 0) chk("first_byte_latency_ge_2", N'(cyc >= 2), N'(1));
      @(posedge clk); #1;
      if (took) i++;
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    if (i < n) chk("byte_feed_timeout", N'(i), N'(n));
  endtask

  task automatic run_msg(input bit gaps, input int hold);
    int cyc = 0;
    int rst_before;
    rst_before = rst_pulses;
    drive_bytes(msg.size(), gaps);
    while (!digest_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("digest_valid_arrives", N'(digest_valid), N'(1));
    chk("digest_value", digest, exp_digest);
    chk("all_elements_issued", N'(exp_elems.size()), '0);
    chk("one_core_rst_per_msg", N'(rst_pulses), N'(rst_before + 1));
    chk("busy_in_out", N'(busy), N'(1));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_digest_valid", N'(digest_valid), N'(1));
      chk("hold_digest_stable", digest, exp_digest);
      chk("hold_s_ready_low", N'(s_ready), '0);
    end
    digest_ready = 1'b1;
    @(posedge clk); #1;
    digest_ready = 1'b0;
    @(negedge clk);
    chk("idle_digest_valid_low", N'(digest_valid), '0);
    chk("idle_busy_low", N'(busy), '0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, N'(s_ready), '0);
    chk({tag, "_core_rst"}, N'(core_rst), '0);
    chk({tag, "_core_en"}, N'(core_en), '0);
    chk({tag, "_digest_valid"}, N'(digest_valid), '0);
    chk({tag, "_busy"}, N'(busy), '0);
    chk({tag, "_core_in"}, core_in, '0);
    chk({tag, "_digest"}, digest, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] lit;
    int cyc;
    int en0;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; digest_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single byte 0xAB.
    msg.delete(); msg.push_back(8'hAB);
    build_expect();
    chk("model_single_elem", exp_elems[0], N'(8'hAB));
`ifdef MIMC_PACK_LEN_PAD_EN
    chk("model_single_len", exp_elems[1], N'(1));
    chk("model_single_digest", exp_digest, N'(16'h0382));
`else
    chk("model_single_digest", exp_digest, N'(8'hB2));
`endif
    run_msg(1'b0, 0);

    // 31 bytes 0x01..0x1F: exactly one full element.
    msg.delete();
    for (int i = 1; i <= 31; i++) msg.push_back(8'(i));
    build_expect();
    lit = 254'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A090807060504030201;
    chk("model_pack31", exp_elems[0], lit);
`ifdef MIMC_PACK_LEN_PAD_EN
    chk("model_len31", exp_elems[1], N'(31));
`else
    chk("model_count31", N'(exp_elems.size()), N'(1));
`endif
    run_msg(1'b0, 0);

    // 32 bytes 0x01..0x20: two elements, digest_ready held low 10 cycles.
    msg.delete();
    for (int i = 1; i <= 32; i++) msg.push_back(8'(i));
    build_expect();
    chk("model_pack32_first", exp_elems[0], lit);
    chk("model_pack32_second", exp_elems[1], N'(8'h20));
    run_msg(1'b0, 10);

    // Same message with s_valid bubbles.
    build_expect();
    run_msg(1'b1, 2);

    // Reset during WAIT of a 3-element message.
    msg.delete();
    for (int i = 0; i < 70; i++) msg.push_back(8'(3 * i + 1));
    build_expect();
    en0 = en_count;
    drive_bytes(31, 1'b0);
    cyc = 0;
    while (en_count == en0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_element_issued", N'(en_count), N'(en0 + 1));
    @(negedge clk);
    chk("pre_reset_busy", N'(busy), N'(1));
    chk("pre_reset_s_ready_low", N'(s_ready), '0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midop_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_elems.delete();
    in_flight = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");
    @(posedge clk); #1;

    // Fresh single byte after the reset.
    msg.delete(); msg.push_back(8'h5C);
    build_expect();
`ifdef MIMC_PACK_LEN_PAD_EN
    chk("model_fresh_digest", exp_digest, N'(16'h01F7));
`else
    chk("model_fresh_digest", exp_digest, N'(8'h63));
`endif
    run_msg(1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mimc_msg_packer.md
# mimc_msg_packer

Upstream front-end for `mimc_feistel_hash`. Accepts an arbitrary-length byte message over a valid/ready stream and packs it into field elements that are always below the BN254 modulus. Feeds the elements one at a time to the hash core's `en`/`in`/`done` interface and returns the final core output as the message digest over a valid/ready handshake. Sits between the byte-oriented host/DMA interface and the hash core.

## Interface

Parameters:
- `N_BITS`, 254: field element / core data width.
- `BYTES_PER_ELEM`, 31: bytes packed per element. `8*BYTES_PER_ELEM` must be less than `N_BITS`, so every element is below the modulus.
- `LEN_BITS`, 64: width of the message byte counter.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_data` in 8: message byte.
- `s_valid` in 1: `s_data` is valid.
- `s_last` in 1: this byte is the final byte of the message.
- `s_ready` out 1: packer accepts a byte; a transfer occurs when `s_valid` and `s_ready` are both high.
- `core_rst` out 1: one-cycle clear pulse to the core at the start of each message.
- `core_en` out 1: one-cycle start pulse to the core.
- `core_in` out N_BITS: element presented to the core.
- `core_out` in N_BITS: core result.
- `core_done` in 1: core result valid (level).
- `digest` out N_BITS: message digest.
- `digest_valid` out 1: `digest` is valid.
- `digest_ready` in 1: consumer accepts the digest.
- `busy` out 1: high in every state except IDLE.

## Operation

- Registered FSM with states IDLE, CLEAR, FILL, ISSUE, WAIT, LEN_ISSUE, LEN_WAIT, OUT.
- **IDLE**
  - `s_ready` is 0.
  - Moves to CLEAR when `s_valid` is 1. No byte is consumed on this transition.
- **CLEAR**
  - `core_rst` is 1 for exactly one cycle.
  - Clears the pack buffer, byte index and length counter.
  - Moves to FILL.
- **FILL**
  - `s_ready` is 1.
  - Each accepted byte is written to buffer bits `[8*idx+7 : 8*idx]`; the first byte lands in the LSB (little-endian).
  - Each accepted byte increments `idx` and the length counter. The length counter wraps modulo 2^LEN_BITS.
  - Moves to ISSUE when `idx` reaches BYTES_PER_ELEM, or when a byte is accepted with `s_last` = 1.
  - A partially filled element keeps its upper bytes at zero.
  - `s_last` is recorded in a sticky `last_seen` flag.
- **ISSUE**
  - `core_en` is 1 for one cycle.
  - `core_in` carries the zero-extended buffer and is held stable until WAIT exits.
  - Moves to WAIT.
- **WAIT**
  - On `core_done` = 1, the next state is:
    - FILL, with buffer and `idx` cleared, if `last_seen` = 0;
    - LEN_ISSUE, if `last_seen` = 1 and MIMC_PACK_LEN_PAD_EN is defined;
    - OUT otherwise, with `digest` <= `core_out`.
- **LEN_ISSUE / LEN_WAIT**
  - Same behaviour as ISSUE and WAIT, with `core_in` = zero-extended length counter in bytes.
  - On `core_done`, `digest` <= `core_out` and the FSM moves to OUT.
- **OUT**
  - `digest_valid` is 1 and `digest` is held stable.
  - On `digest_ready` = 1, moves to IDLE.
- Messages always contain at least 1 byte; the byte carrying `s_last` is part of the message.
- `core_done` is sampled only in WAIT and LEN_WAIT. The core deasserts `done` in the cycle it samples `en`.

## Timing

- **Reset values**: `s_ready`, `core_rst`, `core_en`, `digest_valid`, `busy` = 0; `core_in`, `digest` = 0; state = IDLE. Reset applies immediately, including mid-operation; any partial message is discarded.
- **First byte latency**: the first byte is accepted no earlier than 2 cycles after `s_valid` rises in IDLE (IDLE, CLEAR, then accept in FILL).
- **Per element**:
  - `core_en` rises the cycle after the element completes.
  - FILL resumes, with `s_ready` = 1, the cycle after `core_done` is seen.
- **Digest latency**: `digest_valid` rises the cycle after the final `core_done`.
- **Stalls**:
  - `s_valid` bubbles in FILL only delay the transfers; they never change the packing.
  - `digest_ready` held low keeps the FSM in OUT with `s_ready` = 0.
- **Back-to-back messages**: IDLE takes at least 1 cycle between messages.

## Configuration

- `MIMC_PACK_LEN_PAD_EN` defined:
  - After the last data element, one extra element equal to the message length in bytes is hashed.
  - The digest binds the length, so messages that differ only in trailing zero bytes hash differently.
- Not defined:
  - LEN_ISSUE and LEN_WAIT are unreachable and the length counter is removed.
  - The digest is the core output after the last data element.

## Test plan

- Single byte 0xAB with `s_last` -> one `core_rst` pulse, then `core_en` with `core_in` = 0xAB. With LEN_PAD, a second `core_en` follows with `core_in` = 1. `digest` equals the final `core_out`.
- 31 bytes 0x01..0x1F, `s_last` on 0x1F -> exactly one data element, `core_in` = 0x1F1E...0201. With LEN_PAD, a length element of 31 = 0x1F follows.
- 32 bytes 0x01..0x20 -> two data elements: the 31-byte value above, then `core_in` = 0x20. `s_ready` is 0 from the ISSUE of the first element until its `core_done`.
- Test 3 message with random `s_valid` gaps -> `core_in` sequence and digest identical to the gap-free run.
- `digest_ready` held low for 10 cycles in OUT -> `digest_valid` stays 1, `digest` is stable and `s_ready` stays 0. The FSM moves to IDLE in the cycle `digest_ready` is high.
- `rst` pulsed during WAIT of a 3-element message -> all outputs reset to 0 and state returns to IDLE. A fresh 1-byte message afterwards yields a `core_rst` pulse and the correct single-element digest.
